// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: FSM state encoding and a
// signed saturation helper usable at any width up to 64 bits.
package systolic_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'b001,
      StStream = 3'b010,
      StDone   = 3'b100
   } state_e;

   localparam int unsigned SatW = 64;

   // Caller sign-extends into SatW bits and truncates the result to out_w bits.
   function automatic logic signed [SatW-1:0] sat_signed(input logic signed [SatW-1:0] val,
                                                        input int unsigned out_w);
      logic signed [SatW-1:0] max_v;
      logic signed [SatW-1:0] min_v;
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (val > max_v) begin
         return max_v;
      end else if (val < min_v) begin
         return min_v;
      end
      return val;
   endfunction

endpackage

// File: rtl/systolic_sat.sv
// Combinational signed saturator from DATA_W down to OUT_W bits.
module systolic_sat
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OUT_W  = 16
) (
   input  logic [DATA_W-1:0] din,
   output logic [OUT_W-1:0]  dout
);

   logic signed [SatW-1:0] din_ext;

   always_comb begin
      din_ext = SatW'($signed(din));
      dout    = OUT_W'(sat_signed(din_ext, OUT_W));
   end

endmodule

// File: rtl/systolic_drain.sv
// Drain stage: snapshots saturated PE accumulators on out_rdy and streams them
// row-major over val/rdy, then holds drain_done until out_rdy drops.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int unsigned SIZE   = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              out_rdy,
   input  logic [DATA_W-1:0] acc [SIZE][SIZE],
   output logic              send_val,
   input  logic              send_rdy,
   output logic [OUT_W-1:0]  send_msg,
   output logic              send_last,
   output logic              drain_done
);

   localparam int unsigned NumElem = SIZE * SIZE;
   localparam int unsigned IdxW    = $clog2(NumElem);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumElem - 1);

   state_e          state_q;
   logic [IdxW-1:0] idx_q;
   logic [OUT_W-1:0] snap_q [NumElem];
   logic [OUT_W-1:0] sat_w  [NumElem];

   for (genvar r = 0; r < SIZE; r++) begin : g_row
      for (genvar c = 0; c < SIZE; c++) begin : g_col
         systolic_sat #(
            .DATA_W (DATA_W),
            .OUT_W  (OUT_W)
         ) u_sat (
            .din  (acc[r][c]),
            .dout (sat_w[r*SIZE+c])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         for (int i = 0; i < NumElem; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (out_rdy) begin
                  for (int i = 0; i < NumElem; i++) begin
                     snap_q[i] <= sat_w[i];
                  end
                  idx_q   <= '0;
                  state_q <= StStream;
               end
            end
            StStream: begin
               // out_rdy is deliberately ignored here; a started stream always completes.
               if (send_rdy) begin
                  if (idx_q == LastIdx) begin
                     idx_q   <= '0;
                     state_q <= StDone;
                  end else begin
                     idx_q <= idx_q + IdxW'(1);
                  end
               end
            end
            StDone: begin
               if (!out_rdy) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      send_val   = (state_q == StStream);
      send_last  = send_val && (idx_q == LastIdx);
      drain_done = (state_q == StDone);
      send_msg   = snap_q[idx_q];
   end

endmodule
